data_mem_lsu: RTL and testbench
===============================

# data_mem_lsu

Load/store unit for the MEM stage of the pipelined RV32I core. It is the initiator that drives the word-addressed, asynchronously read, synchronously written data memory. It converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses and performs load alignment and sign/zero extension. Because the memory has no byte enables, SB/SH are done as a two-cycle read-modify-write, with back-pressure to the pipeline while it runs.

## Interface
- No parameters; data width fixed at 32, memory word index fixed at 6 bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  pipeline request present
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low byte/half used for SB/SH)
- ready  out  1  request accepted this cycle when req_valid & ready
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  32  extended load data (0 for stores/errors)
- rsp_err  out  1  misaligned or illegal funct3, qualified by rsp_valid
- mem_read  out  1  to MemRead
- mem_write  out  1  to MemWrite
- mem_addr  out  6  word index = req_addr[7:2]; req_addr[31:8] ignored (aliases)
- mem_wdata  out  32  to data_in
- mem_rdata  in  32  from data_out (combinational)

## Operation
- States: IDLE, RMW_WRITE. ready = (state==IDLE) & rst_n.
- IDLE, accepted load (legal, aligned): mem_read=1 and mem_addr set combinationally. Byte/half is selected by req_addr[1:0] and extended. Result is registered into rsp_data; rsp_valid is pulsed next cycle.
- IDLE, accepted SW: mem_write=1, mem_wdata=req_wdata in the same cycle. rsp_valid next cycle, rsp_data=0.
- IDLE, accepted SB/SH: mem_read=1. mem_rdata is merged with the new byte/half in lane addr[1:0] and captured in a merge register along with the word index. Go to RMW_WRITE.
- RMW_WRITE: mem_write=1 with the merge register and captured index; ready=0. Return to IDLE; rsp_valid next cycle.
- Alignment rules: W needs addr[1:0]=00; H/HU needs addr[0]=0.
- Misaligned or illegal funct3 (011, 110, 111, or 1xx on a store): no mem_read/mem_write. rsp_valid=1 and rsp_err=1 next cycle.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- mem_* outputs are 0 whenever no access is issued.

## Timing
- Reset (rst_n low at an edge): state=IDLE, rsp_valid=0, rsp_data=0, rsp_err=0, merge register=0. While rst_n is low, all mem_* and ready are forced to 0.
- Load / SW / error: accepted cycle N, rsp_valid at N+1, ready high again at N+1.
- SB/SH: accepted N, write cycle N+1 (ready=0), rsp_valid at N+2, ready at N+2.
- Back-to-back ops: a load accepted the cycle after a store observes the stored data, because the write commits at the edge that ends the store's write cycle.
- req_valid while ready=0 is ignored; the requester holds the request until accepted.
- Reset asserted during RMW_WRITE: the write is suppressed (mem_write gated) and no rsp_valid follows.
- rsp_valid never asserts two cycles in a row for the same request.

## Structure
- Package lsu_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state enum {IDLE, RMW_WRITE};
  - a word-index width constant (6).
- One sub-module, lsu_lane_align: combinational load extract/extend and store lane merge from (funct3, addr[1:0], word, wdata). It is shared by both paths.

## Test plan
Memory preloaded: word0=17, word1=9, word2=25.
- LW addr 0x4 accepted at N -> rsp_valid at N+1, rsp_data=0x00000009, rsp_err=0.
- SB addr 0x9 wdata 0x000000AB -> ready=0 at N+1, mem_write at N+1 with 0x0000AB19 to index 2, rsp_valid at N+2; then LW 0x8 -> 0x0000AB19.
- After that store: LB 0x9 -> 0xFFFFFFAB; LBU 0x9 -> 0x000000AB; LHU 0x8 -> 0x0000AB19.
- LH addr 0x3 and LW addr 0x2 -> rsp_err=1 at N+1, mem_read=mem_write=0 throughout; funct3=011 load -> rsp_err=1.
- SH addr 0x0 wdata 0x1234BEEF, with rst_n low during RMW_WRITE -> no write, word0 remains 17, ready=0 during reset, rsp_valid=0.
- SW 0x8 0xDEADBEEF then LW 0x8 in the next cycle -> rsp_data=0xDEADBEEF at the load's N+1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants and types for the MEM-stage load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int IDX_W = 6;

  typedef enum logic {
    IDLE      = 1'b0,
    RMW_WRITE = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/data_mem_lsu_if.sv
// Pipeline-side request/response bundle of the load/store unit.
interface data_mem_lsu_if;
  // Handshake: a request transfers on a cycle where req_valid & ready are both
  // high; the requester holds req_* stable until then. rsp_valid is a one-cycle
  // pulse per accepted request, and rsp_data/rsp_err are meaningful only with it.
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte/half lane handling: load extract+extend and store merge into a word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{offset, 3'b000} +: 8];
    half_v = word[{offset[1], 4'b0000} +: 16];

    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   load_data = {24'h0, byte_v};
      F3_H:    load_data = {{16{half_v[15]}}, half_v};
      F3_HU:   load_data = {16'h0, half_v};
      default: load_data = word;
    endcase

    merge_data = word;
    case (funct3[1:0])
      2'b00:   merge_data[{offset, 3'b000} +: 8]      = wdata[7:0];
      2'b01:   merge_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// MEM-stage load/store unit driving a word-addressed, async-read data memory;
// sub-word stores run as a two-cycle read-modify-write.
module data_mem_lsu
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  data_mem_lsu_if.slave     bus,
  output logic              mem_read,
  output logic              mem_write,
  output logic [IDX_W-1:0]  mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output lsu_state_t        state_dbg
);

  lsu_state_t       state_q, state_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [31:0]      merge_q, merge_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic        ready;
  logic        accept;
  logic        legal_f3;
  logic        aligned;
  logic        ok;
  logic        sub_store;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  lsu_lane_align u_align (
    .funct3     (bus.req_funct3),
    .offset     (bus.req_addr[1:0]),
    .word       (mem_rdata),
    .wdata      (bus.req_wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Unsigned widths exist only for loads; 011/11x are never legal.
  always_comb begin
    legal_f3 = 1'b0;
    case (bus.req_funct3)
      F3_B, F3_H, F3_W: legal_f3 = 1'b1;
      F3_BU, F3_HU:     legal_f3 = ~bus.req_write;
      default:          legal_f3 = 1'b0;
    endcase

    aligned = 1'b0;
    case (bus.req_funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~bus.req_addr[0];
      2'b10:   aligned = (bus.req_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign ok        = legal_f3 & aligned;
  assign sub_store = bus.req_write & (bus.req_funct3[1:0] != 2'b10);
  assign ready     = (state_q == IDLE) & rst_n;
  assign accept    = bus.req_valid & ready;

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = 32'h0;
    rsp_err_d   = 1'b0;
    merge_d     = merge_q;
    idx_d       = idx_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = 32'h0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          rsp_valid_d = 1'b1;
          if (!ok) begin
            rsp_err_d = 1'b1;
          end else if (!bus.req_write) begin
            mem_read   = 1'b1;
            mem_addr   = bus.req_addr[7:2];
            rsp_data_d = load_data;
          end else if (!sub_store) begin
            mem_write = 1'b1;
            mem_addr  = bus.req_addr[7:2];
            mem_wdata = bus.req_wdata;
          end else begin
            mem_read    = 1'b1;
            mem_addr    = bus.req_addr[7:2];
            merge_d     = merge_data;
            idx_d       = bus.req_addr[7:2];
            rsp_valid_d = 1'b0;
            state_d     = RMW_WRITE;
          end
        end
      end
      RMW_WRITE: begin
        mem_write   = 1'b1;
        mem_addr    = idx_q;
        mem_wdata   = merge_q;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A reset landing on the write cycle must not reach the memory.
    if (!rst_n) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_err_q   <= 1'b0;
      merge_q     <= 32'h0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      merge_q     <= merge_d;
      idx_q       <= idx_d;
    end
  end

  assign bus.ready     = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu against a byte-level memory model.
module tb_data_mem_lsu;
  import lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        preload;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  lsu_state_t  state_dbg;

  logic [31:0] mem [64];
  logic [7:0]  ref_bytes [256];
  logic [32:0] exp_q [$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] got_data;
  logic        got_err;

  data_mem_lsu_if lsu_bus ();

  data_mem_lsu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (lsu_bus),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset / memory ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0] <= 32'd17;
      mem[1] <= 32'd9;
      mem[2] <= 32'd25;
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int op_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic model_err(input logic w, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    if (w) legal = (f3 <= 3'd2);
    else   legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return !legal || ((a % op_size(f3)) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    logic [7:0]  ba;
    v = 32'h0;
    for (int i = 0; i < op_size(f3); i++) begin
      ba = a[7:0] + 8'(i);
      v  = v | (32'(ref_bytes[ba]) << (8 * i));
    end
    if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [7:0] ba;
    for (int i = 0; i < op_size(f3); i++) begin
      ba = a[7:0] + 8'(i);
      ref_bytes[ba] = wd[8*i +: 8];
    end
  endtask

  // Scoreboard: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (lsu_bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("sb_rsp_data", lsu_bus.rsp_data, e[31:0]);
        check("sb_rsp_err", 32'(lsu_bus.rsp_err), 32'(e[32]));
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a falling edge; returns just after the response edge.
  task automatic do_op(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n;
    logic err, sub;
    logic [31:0] exp_data;
    lsu_bus.req_valid  = 1'b1;
    lsu_bus.req_write  = w;
    lsu_bus.req_funct3 = f3;
    lsu_bus.req_addr   = a;
    lsu_bus.req_wdata  = wd;
    n = 0;
    while (lsu_bus.ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'd0, 32'd1);
    #1;
    err = model_err(w, f3, a);
    sub = w && !err && (op_size(f3) < 4);
    exp_data = (!w && !err) ? model_load(f3, a) : 32'h0;
    check("acc_mem_read", 32'(mem_read), 32'(!err && (!w || sub)));
    check("acc_mem_write", 32'(mem_write), 32'(!err && w && !sub));
    if (!err) check("acc_mem_addr", 32'(mem_addr), 32'(a[7:2]));
    if (!err && w && !sub) check("acc_mem_wdata", mem_wdata, wd);
    exp_q.push_back({err, exp_data});
    if (w && !err) model_store(f3, a, wd);
    @(posedge clk);
    #1 lsu_bus.req_valid = 1'b0;
    @(negedge clk);
    if (sub) begin
      logic [31:0] word;
      word = model_load(3'd2, {a[31:2], 2'b00});
      check("rmw_ready", 32'(lsu_bus.ready), 32'd0);
      check("rmw_state", 32'(state_dbg), 32'(RMW_WRITE));
      check("rmw_mem_write", 32'(mem_write), 32'd1);
      check("rmw_mem_addr", 32'(mem_addr), 32'(a[7:2]));
      check("rmw_mem_wdata", mem_wdata, word);
      check("rmw_no_early_rsp", 32'(lsu_bus.rsp_valid), 32'd0);
      @(negedge clk);
    end
    check("rsp_valid_latency", 32'(lsu_bus.rsp_valid), 32'd1);
    check("ready_after", 32'(lsu_bus.ready), 32'd1);
    got_data = lsu_bus.rsp_data;
    got_err  = lsu_bus.rsp_err;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    preload = 1'b1;
    lsu_bus.req_valid  = 1'b0;
    lsu_bus.req_write  = 1'b0;
    lsu_bus.req_funct3 = 3'd0;
    lsu_bus.req_addr   = 32'h0;
    lsu_bus.req_wdata  = 32'h0;
    for (int i = 0; i < 256; i++) ref_bytes[i] = 8'h0;
    ref_bytes[0] = 8'd17;
    ref_bytes[4] = 8'd9;
    ref_bytes[8] = 8'd25;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(lsu_bus.ready), 32'd0);
    check("rst_rsp_valid", 32'(lsu_bus.rsp_valid), 32'd0);
    check("rst_rsp_data", lsu_bus.rsp_data, 32'h0);
    check("rst_rsp_err", 32'(lsu_bus.rsp_err), 32'd0);
    check("rst_mem_rw", 32'({mem_read, mem_write}), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    rst_n = 1'b1;
    preload = 1'b0;
    @(negedge clk);

    do_op(1'b0, F3_W, 32'h4, 32'h0);
    check("lw4_lit", got_data, 32'h0000_0009);
    check("lw4_err_lit", 32'(got_err), 32'd0);

    do_op(1'b1, F3_B, 32'h9, 32'h0000_00AB);
    check("sb9_mem2_lit", mem[2], 32'h0000_AB19);
    do_op(1'b0, F3_W, 32'h8, 32'h0);
    check("lw8_lit", got_data, 32'h0000_AB19);
    do_op(1'b0, F3_B, 32'h9, 32'h0);
    check("lb9_lit", got_data, 32'hFFFF_FFAB);
    do_op(1'b0, F3_BU, 32'h9, 32'h0);
    check("lbu9_lit", got_data, 32'h0000_00AB);
    do_op(1'b0, F3_HU, 32'h8, 32'h0);
    check("lhu8_lit", got_data, 32'h0000_AB19);

    do_op(1'b0, F3_H, 32'h3, 32'h0);
    check("lh3_err_lit", 32'(got_err), 32'd1);
    do_op(1'b0, F3_W, 32'h2, 32'h0);
    check("lw2_err_lit", 32'(got_err), 32'd1);
    do_op(1'b0, 3'b011, 32'h0, 32'h0);
    check("f3_011_err_lit", 32'(got_err), 32'd1);
    do_op(1'b1, F3_BU, 32'h4, 32'h55);
    check("sbu_err_lit", 32'(got_err), 32'd1);

    // SH whose write cycle is hit by reset
    lsu_bus.req_valid  = 1'b1;
    lsu_bus.req_write  = 1'b1;
    lsu_bus.req_funct3 = F3_H;
    lsu_bus.req_addr   = 32'h0;
    lsu_bus.req_wdata  = 32'h1234_BEEF;
    #1 check("sh_rst_ready", 32'(lsu_bus.ready), 32'd1);
    @(posedge clk);
    #1 lsu_bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("sh_rst_mem_write", 32'(mem_write), 32'd0);
    check("sh_rst_ready_low", 32'(lsu_bus.ready), 32'd0);
    @(negedge clk);
    check("sh_rst_no_rsp", 32'(lsu_bus.rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("sh_rst_no_rsp2", 32'(lsu_bus.rsp_valid), 32'd0);
    check("sh_rst_word0", mem[0], 32'd17);
    do_op(1'b0, F3_W, 32'h0, 32'h0);
    check("lw0_after_rst_lit", got_data, 32'd17);

    do_op(1'b1, F3_H, 32'h6, 32'h0000_8001);
    do_op(1'b0, F3_H, 32'h6, 32'h0);
    check("lh6_lit", got_data, 32'hFFFF_8001);
    do_op(1'b0, F3_W, 32'h104, 32'h0);
    check("alias_lw_lit", got_data, 32'h8001_0009);

    do_op(1'b1, F3_W, 32'h8, 32'hDEAD_BEEF);
    do_op(1'b0, F3_W, 32'h8, 32'h0);
    check("sw_lw_b2b_lit", got_data, 32'hDEAD_BEEF);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout got=%0d exp=done", cyc);
    $fatal(1, "timeout");
  end

endmodule
